// File: rtl/writeback_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : writeback_stage_if
// Brief    : MEM/WB inputs, late-result handshake and register-file write port.
// Revision : 1.0 - initial release
// ============================================================================
interface writeback_stage_if #(
  parameter int XLEN = 32
);
  logic            StallW;
  logic            FlushW;
  logic            RegWriteM;
  logic [1:0]      ResultSrcM;
  logic [4:0]      RdM;
  logic [2:0]      Funct3M;
  logic [XLEN-1:0] ALUResultM;
  logic [XLEN-1:0] ReadDataM;
  logic [XLEN-1:0] PCPlus4M;
  logic            lr_valid;
  logic [4:0]      lr_rd;
  logic [XLEN-1:0] lr_data;
  logic            lr_ready;
  logic            bubble_req;
  logic            RegWriteW;
  logic [4:0]      RdW;
  logic [XLEN-1:0] ResultW;

  modport master (
    output StallW, FlushW, RegWriteM, ResultSrcM, RdM, Funct3M,
           ALUResultM, ReadDataM, PCPlus4M, lr_valid, lr_rd, lr_data,
    input  lr_ready, bubble_req, RegWriteW, RdW, ResultW
  );

  modport slave (
    input  StallW, FlushW, RegWriteM, ResultSrcM, RdM, Funct3M,
           ALUResultM, ReadDataM, PCPlus4M, lr_valid, lr_rd, lr_data,
    output lr_ready, bubble_req, RegWriteW, RdW, ResultW
  );
endinterface
`default_nettype wire

// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module   : writeback_stage
// Brief    : MEM/WB register, load extension and write-port arbitration
//            between pipeline results and a 1-entry late-result buffer.
// Revision : 1.0 - initial release
// ============================================================================
module writeback_stage #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic              clk,
  input  logic              rst,
  writeback_stage_if.slave  wb
);

  localparam logic [CNT_W-1:0] c_limit = CNT_W'(STARVE_LIMIT);

  logic            r_reg_write;
  logic [1:0]      r_result_src;
  logic [4:0]      r_rd;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_alu;
  logic [XLEN-1:0] r_rdata;
  logic [XLEN-1:0] r_pc4;

  logic            r_buf_valid;
  logic [4:0]      r_buf_rd;
  logic [XLEN-1:0] r_buf_data;
  logic [CNT_W-1:0] r_cnt;

  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [XLEN-1:0] w_load;
  logic [XLEN-1:0] w_pipe_data;
  logic            w_pipe_cand;
  logic            w_drain;
  logic            w_waw;
  logic            w_we;
  logic [4:0]      w_rd;
  logic [XLEN-1:0] w_res;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_reg_write  <= 1'b0;
      r_result_src <= 2'b00;
      r_rd         <= 5'd0;
      r_funct3     <= 3'd0;
      r_alu        <= '0;
      r_rdata      <= '0;
      r_pc4        <= '0;
    end else if (wb.FlushW) begin
      r_reg_write  <= 1'b0;
    end else if (!wb.StallW) begin
      r_reg_write  <= wb.RegWriteM;
      r_result_src <= wb.ResultSrcM;
      r_rd         <= wb.RdM;
      r_funct3     <= wb.Funct3M;
      r_alu        <= wb.ALUResultM;
      r_rdata      <= wb.ReadDataM;
      r_pc4        <= wb.PCPlus4M;
    end
  end

  assign w_byte = r_rdata[{r_alu[1:0], 3'b000} +: 8];
  assign w_half = r_alu[1] ? r_rdata[31:16] : r_rdata[15:0];

  always_comb begin
    w_load = r_rdata;
    case (r_funct3)
      3'b000:  w_load = {{(XLEN-8){w_byte[7]}}, w_byte};
      3'b100:  w_load = {{(XLEN-8){1'b0}}, w_byte};
      3'b001:  w_load = {{(XLEN-16){w_half[15]}}, w_half};
      3'b101:  w_load = {{(XLEN-16){1'b0}}, w_half};
      default: w_load = r_rdata;
    endcase
  end

  always_comb begin
    w_pipe_data = r_alu;
    case (r_result_src)
      2'b01:   w_pipe_data = w_load;
      2'b10:   w_pipe_data = r_pc4;
      default: w_pipe_data = r_alu;
    endcase
  end

  // Pipeline writes win the port; the buffer only drains into empty slots.
  assign w_pipe_cand = r_reg_write && (r_rd != 5'd0);
  assign w_drain     = r_buf_valid && !w_pipe_cand;
  assign w_waw       = r_buf_valid && w_pipe_cand && (r_rd == r_buf_rd);

  always_comb begin
    w_we  = 1'b0;
    w_rd  = 5'd0;
    w_res = '0;
    if (!rst) begin
      if (w_pipe_cand) begin
        w_we  = 1'b1;
        w_rd  = r_rd;
        w_res = w_pipe_data;
      end else if (r_buf_valid) begin
        w_we  = 1'b1;
        w_rd  = r_buf_rd;
        w_res = r_buf_data;
      end
    end
  end

  // Accept only while empty, so a drain cycle can never also accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf_valid <= 1'b0;
      r_buf_rd    <= 5'd0;
      r_buf_data  <= '0;
      r_cnt       <= '0;
    end else if (r_buf_valid) begin
      if (w_drain || w_waw) begin
        r_buf_valid <= 1'b0;
        r_cnt       <= '0;
      end else if (r_cnt != c_limit) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end else if (wb.lr_valid && (wb.lr_rd != 5'd0)) begin
      r_buf_valid <= 1'b1;
      r_buf_rd    <= wb.lr_rd;
      r_buf_data  <= wb.lr_data;
      r_cnt       <= '0;
    end
  end

  assign wb.lr_ready   = !rst && !r_buf_valid;
  assign wb.bubble_req = !rst && r_buf_valid && (r_cnt == c_limit);
  assign wb.RegWriteW  = w_we;
  assign wb.RdW        = w_rd;
  assign wb.ResultW    = w_res;

endmodule
`default_nettype wire

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- MEM/WB pipeline register plus writeback select for the 5-stage RV32I pipeline.
- Sits directly upstream of the register file and drives its single write port (RegWriteW, RdW, ResultW).
- Performs load byte/half extraction and sign/zero extension.
- Arbitrates the write port between in-order pipeline results and late results from the multi-cycle unit (divider), using a 1-entry buffer and a starvation counter that requests a pipeline bubble.

Parameters:
XLEN, 32, datapath width
STARVE_LIMIT, 4, cycles a buffered late result may wait before bubble_req asserts (1..2^CNT_W-1)
CNT_W, 3, width of starvation counter

Ports:
clk  input  1  pipeline clock; all state updates on posedge
rst  input  1  synchronous reset, active-high
StallW  input  1  hold MEM/WB register contents
FlushW  input  1  invalidate MEM/WB register (clears write enable)
RegWriteM  input  1  MEM-stage instruction writes rd
ResultSrcM  input  2  00 ALU, 01 load data, 10 PC+4, 11 reserved (treated as ALU)
RdM  input  5  destination register
Funct3M  input  3  load type
ALUResultM  input  XLEN  ALU result / load address
ReadDataM  input  XLEN  raw aligned memory word
PCPlus4M  input  XLEN  link value
lr_valid  input  1  late result offered
lr_rd  input  5  late result destination
lr_data  input  XLEN  late result value
lr_ready  output  1  late result accepted this cycle when high with lr_valid
bubble_req  output  1  request upstream to inject a non-writing bubble
RegWriteW  output  1  register file write enable
RdW  output  5  register file write address
ResultW  output  XLEN  register file write data (also hazard-unit forwarding source)

Behaviour:
- Reset (rst=1 at posedge):
  - MEM/WB register cleared; buffer invalid; counter 0.
  - Outputs RegWriteW=0, RdW=0, ResultW=0, bubble_req=0, lr_ready=0 while rst=1.
- MEM/WB register, posedge:
  - FlushW=1: RegWrite_q<=0, other fields don't-care. Flush has priority over stall.
  - Else StallW=1: hold all fields.
  - Else capture RegWriteM, ResultSrcM, RdM, Funct3M, ALUResultM[1:0], ALUResultM, ReadDataM, PCPlus4M.
- Load extraction (combinational from _q), offset = ALUResult_q[1:0]:
  - 000 LB: byte at offset, sign-extend. 100 LBU: same, zero-extend.
  - 001 LH: half at offset[1], sign-extend; offset[0] ignored. 101 LHU: same, zero-extend.
  - 010 LW and all other codes: full word.
- Pipe candidate = RegWrite_q && (Rd_q != 0).
- Write port is combinational from registered state; the register file samples it at negedge within the same cycle.
  - Pipe candidate: RegWriteW=1, RdW=Rd_q, ResultW=selected pipe value.
  - Else buffer valid: RegWriteW=1, RdW=buf_rd, ResultW=buf_data. This is a drain; buffer clears at posedge.
  - Else RegWriteW=0, RdW=0, ResultW=0.
  - Rd_q=0 never writes and never blocks a drain.
- Late buffer:
  - lr_ready = !rst && !buf_valid.
  - On lr_valid && lr_ready, capture at posedge. If lr_rd=0, accept and discard (buffer stays invalid).
  - No accept in the same cycle as a drain; lr_ready re-asserts the cycle after.
- WAW: if buffer valid and the pipe candidate has Rd_q==buf_rd, the buffered entry is discarded at that posedge (pipeline instruction is newer); counter resets.
- Starvation:
  - Counter increments each cycle the buffer is valid and not drained or discarded; saturates at STARVE_LIMIT.
  - bubble_req = buf_valid && (cnt == STARVE_LIMIT). Held until drain or discard; counter then returns to 0.
- StallW with a held pipe candidate rewrites the same value each cycle (harmless); the buffer cannot drain during that time.
- Reset mid-operation discards a pending buffer entry and any MEM/WB contents.

Test Plan:
- Load extraction: ReadDataM=0x8081_F2A4, addr low bits 01, LB -> ResultW=0xFFFF_FFF2; LBU -> 0x0000_00F2; LH addr 10 -> 0xFFFF_8081; LHU -> 0x0000_8081.
- Select and flush: ALU result 0x1234 to x5 -> RegWriteW=1, RdW=5, ResultW=0x1234 one cycle after capture. Same with FlushW=1 -> RegWriteW=0. RdM=0 -> RegWriteW=0.
- Late drain on bubble: lr_valid, lr_rd=7, lr_data=0xDEAD while pipe writes x3. Next cycle x3 written. First non-writing slot writes x7=0xDEAD. lr_ready low from accept until the cycle after drain.
- Starvation: buffer holds x9; pipe writes x1..x6 back-to-back -> bubble_req rises exactly 4 cycles after capture and falls the cycle after the x9 drain.
- WAW discard: buffer holds x4=0x11; pipe writes x4=0x22 -> RdW=4, ResultW=0x22; buffer invalid next cycle; x4 never written with 0x11.
- Reset mid-operation: buffer valid and StallW=1 when rst=1 -> next cycle all outputs 0, lr_ready=0; after rst drops, lr_ready=1 and no stale write occurs.
